serial_frame_transmitter: RTL and testbench
===========================================

// Module: serial_frame_transmitter
//
// PURPOSE
//   Parallel-to-serial frame transmitter. It is the sending end of the serial link whose receiver is built from our edge-triggered D flip-flops.
//   It accepts one DATA_W word through a valid/ready handshake and sends it as one frame on a single line.
//   Frame order: start bit (0), data bits LSB first, optional even-parity bit, stop bit (1).
//   Sits between a producer (CPU/test logic) and the board-level serial pin.
//
// PARAMETERS
//   DATA_W        8   data bits per frame (1..16)
//   CLKS_PER_BIT  4   clk cycles each bit is held on tx_serial (>=1)
//   PARITY_EN     1   1 = append even-parity bit after data; 0 = no parity bit
//
// PORTS
//   clk        in   1       single clock; all state changes on posedge clk
//   rst        in   1       reset, synchronous and active-high
//   tx_data    in   DATA_W  word to send; sampled only at handshake
//   tx_valid   in   1       producer has a word on tx_data
//   tx_ready   out  1       transmitter can accept a word (IDLE only)
//   tx_serial  out  1       serial line, registered; idles high
//   tx_busy    out  1       high while a frame is in progress (state != IDLE)
//   tx_done    out  1       one-cycle pulse on the last cycle of the stop bit
//
// BEHAVIOUR
//   - Reset (rst=1 at posedge clk) puts the block in the following state:
//     state=IDLE, tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, counters=0, shift reg=0.
//   - Reset wins over everything. If reset arrives mid-frame:
//     the frame is abandoned, and tx_serial=1 from the next cycle.
//     No tx_done pulse is issued.
//   - Handshake: a word is accepted at the posedge where tx_valid & tx_ready.
//     On that same edge, tx_data is latched, state->START and tx_serial<=0.
//   - After acceptance, changes on tx_data have no effect on the frame.
//   - tx_valid while busy is ignored, because tx_ready=0. No queueing.
//   - FSM states are IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
//     Each non-IDLE state lasts exactly CLKS_PER_BIT cycles.
//     DATA lasts DATA_W*CLKS_PER_BIT cycles.
//   - Bit period counter: counts 0..CLKS_PER_BIT-1 and advances the bit when it wraps.
//     With CLKS_PER_BIT=1 it is inert, and every cycle advances the bit.
//   - Data bit counter: counts 0..DATA_W-1 and leaves DATA after bit DATA_W-1.
//     Shift right one place per bit; tx_serial <= shift[0].
//   - Parity = XOR of the latched word (even parity), so the total count of ones including the parity bit is even.
//   - Frame length in cycles: F = (2 + DATA_W + PARITY_EN) * CLKS_PER_BIT.
//     The start bit appears on the cycle after the accept edge.
//   - tx_done is high for exactly one cycle, on the final cycle of STOP.
//     On the edge that ends that cycle, state->IDLE and tx_ready=1.
//   - Back-to-back frames: if tx_valid is held, the next word is accepted on the first IDLE cycle.
//     The line is then high for the stop bit plus exactly 1 cycle.
//   - tx_busy = (state != IDLE); tx_ready = (state == IDLE). Both are driven from registered state.
//
// STRUCTURE
//   - Shared package serial_pkg holds:
//       the FSM state encoding (IDLE/START/DATA/PARITY/STOP, 3-bit),
//       the line idle level constant (1'b1),
//       the start level constant (1'b0).
//     A future matching receiver reuses it.
//   - One sub-module, bit_period_counter (parameter CLKS_PER_BIT):
//       inputs clk, rst, clear; output tick when the count reaches CLKS_PER_BIT-1.
//   - The FSM, shift register and parity live in the top module.
//
// TESTING (DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=1 unless stated)
//   1. rst held 3 cycles, then released.
//      -> tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0 on every cycle.
//   2. Send 0xA5.
//      -> line shows 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1.
//      -> each bit lasts 4 cycles; tx_done is pulsed 44 cycles after accept.
//   3. tx_valid held with 0x07, then 0xFF.
//      -> frame 1 parity = 1; frame 2 parity = 0.
//      -> second accept occurs on the cycle after tx_done; line high for exactly 5 cycles between frames.
//   4. Pulse tx_valid with 0x3C at cycle 10 of a frame carrying 0x81.
//      -> it is ignored; the 0x81 frame is unchanged, and no second frame follows.
//   5. Assert rst for 1 cycle at cycle 20 of a frame.
//      -> next cycle tx_serial=1, tx_ready=1; no tx_done pulse.
//      -> a new word is accepted normally afterwards.
//   6. With CLKS_PER_BIT=1, PARITY_EN=0, send 0x80.
//      -> 10-cycle frame: 0,0,0,0,0,0,0,0,1,1; tx_done on cycle 10.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: FSM state encoding and line levels.
// The transmitter uses them now; a matching receiver can reuse them later.
package serial_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/bit_period_counter.sv
// Counts clk cycles inside one bit period; tick marks the last cycle of the bit.
// With CLKS_PER_BIT=1 the count never moves and tick is permanently high.
module bit_period_counter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_frame_transmitter.sv
// Parallel-to-serial frame transmitter: start(0), data LSB first,
// optional even parity, stop(1). One word per valid/ready handshake.
module serial_frame_transmitter
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  logic [2:0]        state;
  logic [DATA_W-1:0] shift;
  logic [BIT_W-1:0]  bit_cnt;
  logic              parity_bit;
  logic              tick;

  function automatic logic even_parity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction

  // Bit timing restarts from zero on the accept edge because IDLE holds it clear.
  bit_period_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_period_counter (
    .clk  (clk),
    .rst  (rst),
    .clear(state == ST_IDLE),
    .tick (tick)
  );

  assign tx_ready = (state == ST_IDLE);
  assign tx_busy  = (state != ST_IDLE);
  assign tx_done  = (state == ST_STOP) && tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx_serial  <= LINE_IDLE;
      shift      <= '0;
      parity_bit <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tx_valid) begin
            state      <= ST_START;
            tx_serial  <= LINE_START;
            shift      <= tx_data;
            parity_bit <= even_parity(tx_data);
            bit_cnt    <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            state     <= ST_DATA;
            tx_serial <= shift[0];
            shift     <= shift >> 1;
            bit_cnt   <= '0;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                state     <= ST_PARITY;
                tx_serial <= parity_bit;
              end else begin
                state     <= ST_STOP;
                tx_serial <= LINE_IDLE;
              end
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              tx_serial <= shift[0];
              shift     <= shift >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state     <= ST_STOP;
            tx_serial <= LINE_IDLE;
          end
        end
        ST_STOP: begin
          if (tick) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          tx_serial <= LINE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Self-checking bench: instance 0 uses 8 bits / 4 clks per bit / parity,
// instance 1 uses 8 bits / 1 clk per bit / no parity.
module tb_serial_frame_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid [2];
  logic [7:0] data  [2];
  logic       ready [2];
  logic       ser   [2];
  logic       busy  [2];
  logic       done  [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_frame_transmitter #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut0 (
    .clk(clk), .rst(rst), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .tx_serial(ser[0]), .tx_busy(busy[0]), .tx_done(done[0])
  );

  serial_frame_transmitter #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut1 (
    .clk(clk), .rst(rst), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .tx_serial(ser[1]), .tx_busy(busy[1]), .tx_done(done[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int cpb_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int pen_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  // Reference line level for bit slot idx of a frame carrying w.
  function automatic logic ref_bit(input logic [7:0] w, input int idx, input int pen);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return w[idx-1];
    if (pen != 0 && idx == 9) return logic'($countones(w) % 2);
    return 1'b1;
  endfunction

  task automatic check_idle(input int d, input string tag);
    check({tag, "_serial"}, 32'(ser[d]),   32'd1);
    check({tag, "_ready"},  32'(ready[d]), 32'd1);
    check({tag, "_busy"},   32'(busy[d]),  32'd0);
    check({tag, "_done"},   32'(done[d]),  32'd0);
  endtask

  // Present a word at a negedge; it is accepted at the following posedge.
  task automatic offer(input int d, input logic [7:0] w, input bit hold, input logic [7:0] next_w);
    @(negedge clk);
    valid[d] = 1'b1;
    data[d]  = w;
    check("offer_ready", 32'(ready[d]), 32'd1);
    @(posedge clk);
    #1;
    valid[d] = hold;
    data[d]  = hold ? next_w : 8'($urandom);
  endtask

  // Called just after an accept edge; checks every cycle of the frame, then the first idle cycle.
  task automatic check_frame(input int d, input logic [7:0] w, input int inject_at, input int abort_at);
    int f;
    f = (2 + 8 + pen_of(d)) * cpb_of(d);
    for (int k = 0; k < f; k++) begin
      @(negedge clk);
      check("frame_serial", 32'(ser[d]), 32'(ref_bit(w, k / cpb_of(d), pen_of(d))));
      check("frame_busy",   32'(busy[d]),  32'd1);
      check("frame_ready",  32'(ready[d]), 32'd0);
      check("frame_done",   32'(done[d]),  32'(k == f - 1));
      if (k == inject_at) begin
        valid[d] = 1'b1;
        data[d]  = 8'h3C;
      end
      if (k == inject_at + 1) begin
        valid[d] = 1'b0;
        data[d]  = 8'($urandom);
      end
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle(d, "abort");
        return;
      end
    end
    @(negedge clk);
    check_idle(d, "post_frame");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] w;
    logic [7:0] nw;
    rst      = 1'b1;
    valid[0] = 1'b0;
    valid[1] = 1'b0;
    data[0]  = 8'h00;
    data[1]  = 8'h00;

    // Reset held 3 cycles, then released
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle(0, "reset0");
      check_idle(1, "reset1");
      if (i == 1) rst = 1'b0;
    end

    // 0xA5 single frame
    offer(0, 8'hA5, 1'b0, 8'h00);
    check_frame(0, 8'hA5, -10, -10);

    // Back-to-back 0x07 then 0xFF
    offer(0, 8'h07, 1'b1, 8'hFF);
    check_frame(0, 8'h07, -10, -10);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    data[0]  = 8'h00;
    check_frame(0, 8'hFF, -10, -10);

    // Word offered while busy must be ignored
    offer(0, 8'h81, 1'b0, 8'h00);
    check_frame(0, 8'h81, 9, -10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle(0, "no_second_frame");
    end

    // Reset mid-frame, then a normal frame
    offer(0, 8'h5A, 1'b0, 8'h00);
    check_frame(0, 8'h5A, -10, 19);
    offer(0, 8'hC3, 1'b0, 8'h00);
    check_frame(0, 8'hC3, -10, -10);

    // One clock per bit, no parity
    offer(1, 8'h80, 1'b0, 8'h00);
    check_frame(1, 8'h80, -10, -10);

    // Randomized frames on both configurations
    for (int n = 0; n < 24; n++) begin
      int d;
      d  = (n % 3 == 2) ? 1 : 0;
      w  = 8'($urandom);
      nw = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        offer(d, w, 1'b1, nw);
        check_frame(d, w, -10, -10);
        @(posedge clk);
        #1;
        valid[d] = 1'b0;
        data[d]  = 8'($urandom);
        check_frame(d, nw, -10, -10);
      end else begin
        offer(d, w, 1'b0, 8'h00);
        check_frame(d, w, -10, -10);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
